// File: rtl/ifetch_queue.sv
// ifetch_queue -- program counter plus a DEPTH-entry prefetch queue in front of
// a synchronous instruction memory with a 1-cycle read latency. Instructions go
// to decode over a valid/ready handshake. A taken branch redirects fetch.
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   iBr_taken, iBr_dir      redirect request and its target address
//   oImem_req, oImem_addr   memory read request; the address is the PC register
//   iImem_data              read data, returned the cycle after oImem_req
//   oInst_valid/iInst_ready queue-head handshake with decode
//   oFetchedInst, oInst_pc  head instruction and its address
//   oNew_pc                 oInst_pc + 1, used downstream for branch targets
//   oFlush_cnt, oStall_cnt  saturating perf counters, present only when
//                           IFETCH_PERF_EN is defined
//
// Optional feature macro: IFETCH_PERF_EN.
module ifetch_queue #(
  parameter int                ADDR_W   = 10,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iBr_taken,
  input  logic [ADDR_W-1:0]  iBr_dir,
  output logic               oImem_req,
  output logic [ADDR_W-1:0]  oImem_addr,
  input  logic [INSTR_W-1:0] iImem_data,
  output logic               oInst_valid,
  input  logic               iInst_ready,
  output logic [INSTR_W-1:0] oFetchedInst,
  output logic [ADDR_W-1:0]  oInst_pc,
`ifdef IFETCH_PERF_EN
  output logic [15:0]        oFlush_cnt,
  output logic [15:0]        oStall_cnt,
`endif
  output logic [ADDR_W-1:0]  oNew_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;          // count spans 0..DEPTH

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               infl_q, infl_d;
  logic [ADDR_W-1:0]  infl_addr_q, infl_addr_d;
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic [INSTR_W-1:0] q_instr_q [DEPTH];
  logic [ADDR_W-1:0]  q_pc_q    [DEPTH];
  logic               pop, wr_en;
  logic [CW:0]        occ;

  assign oInst_valid = (count_q != '0);
  assign pop         = oInst_valid && iInst_ready;

  // Occupancy after this cycle's pop, counting the read still in flight.
  // pop implies count_q >= 1, so the subtraction cannot underflow.
  assign occ        = {1'b0, count_q} + (CW+1)'(infl_q) - (CW+1)'(pop);
  assign oImem_req  = !reset && !iBr_taken && (occ < (CW+1)'(DEPTH));
  assign oImem_addr = pc_q;

  always_comb begin
    pc_d        = pc_q;
    infl_d      = 1'b0;
    infl_addr_d = infl_addr_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    wr_en       = 1'b0;
    if (iBr_taken) begin
      // Returning data is dropped and the queue flushed; a same-cycle pop
      // has already been taken by decode, so nothing else is needed for it.
      pc_d   = iBr_dir;
      head_d = '0;
      tail_d = '0;
      count_d = '0;
    end else begin
      if (oImem_req) begin
        pc_d        = pc_q + ADDR_W'(1);
        infl_d      = 1'b1;
        infl_addr_d = pc_q;
      end
      if (infl_q) begin
        wr_en  = 1'b1;
        tail_d = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      count_d = count_q + CW'(infl_q) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      pc_q        <= pc_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // Entry storage needs no reset: count_q alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      q_instr_q[tail_q] <= iImem_data;
      q_pc_q[tail_q]    <= infl_addr_q;
    end
  end

  assign oFetchedInst = oInst_valid ? q_instr_q[head_q] : '0;
  assign oInst_pc     = oInst_valid ? q_pc_q[head_q]    : '0;
  assign oNew_pc      = oInst_valid ? q_pc_q[head_q] + ADDR_W'(1) : '0;

`ifdef IFETCH_PERF_EN
  logic [15:0] flush_q, stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      flush_q <= '0;
      stall_q <= '0;
    end else begin
      if (iBr_taken && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
      if (oInst_valid && !iInst_ready && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign oFlush_cnt = flush_q;
  assign oStall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (ADDR_W=10, INSTR_W=16, DEPTH=4, RESET_PC=0).
// The memory model returns 16'h8000 | addr one cycle after a request, so the
// instruction value also identifies the address it was fetched from.
module tb_ifetch_queue;
  localparam int AW = 10;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          br = 1'b0;
  logic [AW-1:0] dir = '0;
  logic          ready = 1'b0;
  logic          req, valid;
  logic [AW-1:0] addr, ipc, npc;
  logic [IW-1:0] imem_data = '0, inst;
`ifdef IFETCH_PERF_EN
  logic [15:0]   flush_cnt, stall_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  ifetch_queue #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(4), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .iBr_taken(br), .iBr_dir(dir),
    .oImem_req(req), .oImem_addr(addr), .iImem_data(imem_data),
    .oInst_valid(valid), .iInst_ready(ready), .oFetchedInst(inst),
    .oInst_pc(ipc),
`ifdef IFETCH_PERF_EN
    .oFlush_cnt(flush_cnt), .oStall_cnt(stall_cnt),
`endif
    .oNew_pc(npc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= req ? (16'h8000 | 16'(addr)) : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Apply one cycle of inputs just after the rising edge, sample at the falling edge.
  task automatic cyc(input logic rst, input logic rdy, input logic b, input logic [AW-1:0] d);
    @(posedge clk);
    #1;
    reset = rst; ready = rdy; br = b; dir = d;
    @(negedge clk);
  endtask

  task automatic head(input string tag, input int pc);
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_pc"},    32'(ipc),   32'(pc));
    check({tag, "_npc"},   32'(npc),   32'((pc + 1) % 1024));
    check({tag, "_inst"},  32'(inst),  32'(16'h8000 | 16'(pc)));
  endtask

  task automatic restart;
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    // Reset state
    restart();
    check("rst_req",   32'(req),   32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_inst",  32'(inst),  32'd0);
    check("rst_pc",    32'(ipc),   32'd0);
    check("rst_npc",   32'(npc),   32'd0);

    // Streaming: one instruction per cycle from cycle 2
    for (int c = 0; c < 8; c++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      check("str_req",  32'(req),  32'd1);
      check("str_addr", 32'(addr), 32'(c));
      if (c < 2) check("str_valid0", 32'(valid), 32'd0);
      else       head("str", c - 2);
    end

    // Backpressure: fills to 4 entries, then drains without gap or duplicate
    restart();
    for (int c = 0; c < 8; c++) begin
      cyc(1'b0, 1'b0, 1'b0, '0);
      check("bp_req", 32'(req), 32'(c <= 3));
      if (c >= 4) check("bp_addr", 32'(addr), 32'd4);
      if (c < 2) check("bp_valid0", 32'(valid), 32'd0);
      else       head("bp_hold", 0);
    end
    for (int c = 8; c < 14; c++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      head("bp_drain", c - 8);
      if (c == 8) begin
        check("bp_resume_req",  32'(req),  32'd1);
        check("bp_resume_addr", 32'(addr), 32'd4);
      end
    end

    // Redirect with entries queued and a read in flight
    restart();
    for (int c = 0; c < 3; c++) cyc(1'b0, 1'b0, 1'b0, '0);
    head("rd_pre", 0);
    cyc(1'b0, 1'b0, 1'b1, 10'd50);
    check("rd_req_blk", 32'(req), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("rd_addr", 32'(addr), 32'd50);
    check("rd_req",  32'(req),  32'd1);
    check("rd_v0",   32'(valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("rd_addr1", 32'(addr), 32'd51);
    check("rd_v1",    32'(valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    head("rd_h50", 50);
    cyc(1'b0, 1'b1, 1'b0, '0);
    head("rd_h51", 51);

    // Redirect with a full queue and a same-cycle pop, then wrap at 1023
    restart();
    for (int c = 0; c < 6; c++) cyc(1'b0, 1'b0, 1'b0, '0);
    check("fq_req", 32'(req), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 10'd100);
    head("fq_pop", 0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("fq_v0",   32'(valid), 32'd0);
    check("fq_addr", 32'(addr),  32'd100);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("fq_v1",   32'(valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    head("fq_h100", 100);
    cyc(1'b0, 1'b1, 1'b1, 10'd1023);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("wr_addr", 32'(addr), 32'd1023);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("wr_addr0", 32'(addr), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    head("wr_h1023", 1023);
    check("wr_npc0", 32'(npc), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    head("wr_h0", 0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    head("wr_h1", 1);

    // Reset mid-stream with a full queue
    restart();
    for (int c = 0; c < 6; c++) cyc(1'b0, 1'b0, 1'b0, '0);
    head("mr_full", 0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    check("mr_req_rst", 32'(req), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("mr_v0",   32'(valid), 32'd0);
    check("mr_req",  32'(req),   32'd1);
    check("mr_addr", 32'(addr),  32'd0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("mr_v1",   32'(valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    head("mr_h0", 0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    head("mr_h1", 1);

`ifdef IFETCH_PERF_EN
    restart();
    check("pf_rst_flush", 32'(flush_cnt), 32'd0);
    check("pf_rst_stall", 32'(stall_cnt), 32'd0);
    for (int c = 0; c < 7; c++) cyc(1'b0, 1'b0, 1'b0, '0);   // stalls in cycles 2..6
    for (int c = 0; c < 3; c++) cyc(1'b0, 1'b1, 1'b1, 10'd7);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("pf_flush", 32'(flush_cnt), 32'd3);
    check("pf_stall", 32'(stall_cnt), 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
